// File: rtl/dino_game_state_engine_pkg.sv
// Shared definitions for the dino game state engine.
//   game_state_e : 2-bit FSM encoding (idle, running, paused, game over)
//   Def*         : default geometry/physics constants, also used by the display controller
//   sat_sub      : 12-bit subtraction clamped at zero
package dino_game_state_engine_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StOver   = 2'd3
  } game_state_e;

  localparam int unsigned DefDinoX      = 100;
  localparam int unsigned DefGroundY    = 320;
  localparam int unsigned DefObstStartX = 680;
  localparam int unsigned DefJumpV      = 14;
  localparam int unsigned DefGravity    = 1;
  localparam int unsigned DefSpeedInit  = 4;
  localparam int unsigned DefSpeedMax   = 12;
  localparam int unsigned DefSpeedStep  = 5;

  function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? (a - b) : 12'd0;
  endfunction

endpackage

// File: rtl/dino_game_state_engine_rise_edge.sv
// Rising-edge detector: one register plus AND-NOT, giving a 1-clk pulse on each 0->1 transition.
//   clk   : system clock
//   reset : synchronous active-low reset
//   sig   : level input
//   pulse : high for one clk when sig rises
module dino_game_state_engine_rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/dino_game_state_engine.sv
// Game-state producer for the VGA display path. Advances once per video frame (rising edge of
// screen_ready) and produces dino/obstacle coordinates, score, pause and game_over flags.
//   clk, reset          : clock, synchronous active-low reset
//   screen_ready        : frame-boundary level from display
//   collision_detected  : dino/obstacle overlap from display
//   jump_btn, pause_btn : debounced buttons
//   x_coor, y_coor      : dino left / bottom edge
//   x_coor_obstacle     : obstacle left edge
//   y_coor_obstacle     : obstacle bottom edge (constant ground level)
//   game_over, pause    : state flags for the display overlay
//   score               : obstacles cleared this run (saturating)
module dino_game_state_engine
  import dino_game_state_engine_pkg::*;
#(
  parameter int unsigned DINO_X       = DefDinoX,
  parameter int unsigned GROUND_Y     = DefGroundY,
  parameter int unsigned OBST_START_X = DefObstStartX,
  parameter int unsigned JUMP_V       = DefJumpV,
  parameter int unsigned GRAVITY      = DefGravity,
  parameter int unsigned SPEED_INIT   = DefSpeedInit,
  parameter int unsigned SPEED_MAX    = DefSpeedMax,
  parameter int unsigned SPEED_STEP   = DefSpeedStep
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screen_ready,
  input  logic        collision_detected,
  input  logic        jump_btn,
  input  logic        pause_btn,
  output logic [31:0] x_coor,
  output logic [31:0] y_coor,
  output logic [31:0] x_coor_obstacle,
  output logic [31:0] y_coor_obstacle,
  output logic        game_over,
  output logic        pause,
  output logic [15:0] score
);

  localparam logic [11:0] DinoX      = 12'(DINO_X);
  localparam logic [11:0] GroundY    = 12'(GROUND_Y);
  localparam logic [11:0] ObstStartX = 12'(OBST_START_X);
  localparam logic [11:0] JumpV12    = 12'(JUMP_V);
  localparam logic [7:0]  JumpV      = 8'(JUMP_V);
  localparam logic [7:0]  Gravity    = 8'(GRAVITY);
  localparam logic [7:0]  SpeedInit  = 8'(SPEED_INIT);
  localparam logic [7:0]  SpeedMax   = 8'(SPEED_MAX);
  localparam logic [15:0] StepLast   = 16'(SPEED_STEP - 1);

  logic tick, jump_e, pause_e;

  dino_game_state_engine_rise_edge u_tick_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (screen_ready),
    .pulse (tick)
  );

  dino_game_state_engine_rise_edge u_jump_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (jump_btn),
    .pulse (jump_e)
  );

  dino_game_state_engine_rise_edge u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (pause_btn),
    .pulse (pause_e)
  );

  game_state_e       state_q, state_d;
  logic [11:0]       y_q, y_d;
  logic signed [7:0] vel_q, vel_d;
  logic              jump_latched_q, jump_latched_d;
  logic [11:0]       obst_q, obst_d;
  logic [7:0]        speed_q, speed_d;
  logic [15:0]       score_q, score_d;
  // Counts wraps since the last speed increment; avoids a modulo on the score.
  logic [15:0]       step_q, step_d;
  logic              game_over_q, game_over_d;
  logic              pause_q, pause_d;

  logic signed [13:0] y_sum;
  logic               grounded;
  logic               jump_go;

  always_comb begin
    state_d        = state_q;
    y_d            = y_q;
    vel_d          = vel_q;
    jump_latched_d = jump_latched_q;
    obst_d         = obst_q;
    speed_d        = speed_q;
    score_d        = score_q;
    step_d         = step_q;

    y_sum    = $signed({2'b00, y_q}) + $signed({{6{vel_q[7]}}, vel_q});
    grounded = (y_q == GroundY) && (vel_q == 8'sd0);
    // A press in the same clk as the tick counts for that tick.
    jump_go  = jump_latched_q | jump_e;

    case (state_q)
      StIdle: begin
        if (jump_e) state_d = StRun;
      end

      StRun: begin
        if (jump_e) jump_latched_d = 1'b1;
        if (tick && collision_detected) begin
          state_d = StOver;
        end else if (pause_e) begin
          state_d = StPaused;
        end else if (tick) begin
          jump_latched_d = 1'b0;

          if (grounded) begin
            if (jump_go) begin
              vel_d = $signed(8'd0 - JumpV);
              y_d   = sat_sub(y_q, JumpV12);
            end
          end else if (y_sum >= $signed({2'b00, GroundY})) begin
            y_d   = GroundY;
            vel_d = 8'sd0;
          end else begin
            y_d   = y_sum[13] ? 12'd0 : y_sum[11:0];
            vel_d = vel_q + $signed(Gravity);
          end

          if (obst_q < {4'b0000, speed_q}) begin
            obst_d = ObstStartX;
            if (score_q != 16'hFFFF) begin
              score_d = score_q + 16'd1;
              if (step_q == StepLast) begin
                step_d = 16'd0;
                if (speed_q < SpeedMax) speed_d = speed_q + 8'd1;
              end else begin
                step_d = step_q + 16'd1;
              end
            end
          end else begin
            obst_d = obst_q - {4'b0000, speed_q};
          end
        end
      end

      StPaused: begin
        if (pause_e) state_d = StRun;
      end

      StOver: begin
        if (jump_e) begin
          state_d        = StRun;
          y_d            = GroundY;
          vel_d          = 8'sd0;
          jump_latched_d = 1'b0;
          obst_d         = ObstStartX;
          speed_d        = SpeedInit;
          score_d        = 16'd0;
          step_d         = 16'd0;
        end
      end

      default: state_d = StIdle;
    endcase

    game_over_d = (state_d == StOver);
    pause_d     = (state_d == StPaused);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      y_q            <= GroundY;
      vel_q          <= 8'sd0;
      jump_latched_q <= 1'b0;
      obst_q         <= ObstStartX;
      speed_q        <= SpeedInit;
      score_q        <= 16'd0;
      step_q         <= 16'd0;
      game_over_q    <= 1'b0;
      pause_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      y_q            <= y_d;
      vel_q          <= vel_d;
      jump_latched_q <= jump_latched_d;
      obst_q         <= obst_d;
      speed_q        <= speed_d;
      score_q        <= score_d;
      step_q         <= step_d;
      game_over_q    <= game_over_d;
      pause_q        <= pause_d;
    end
  end

  assign x_coor          = {20'd0, DinoX};
  assign y_coor          = {20'd0, y_q};
  assign x_coor_obstacle = {20'd0, obst_q};
  assign y_coor_obstacle = {20'd0, GroundY};
  assign game_over       = game_over_q;
  assign pause           = pause_q;
  assign score           = score_q;

endmodule
